// File: rtl/f_fetch_queue.sv
// Prefetch queue between fetch and decode: buffers {exc, pc, instr} entries,
// stalls the PC when full and drops everything on a control-flow redirect.
module f_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_6FFC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              F_Pc,
    input  logic [31:0]              F_Instr,
    input  logic                     flush,
    output logic                     EN_Pc,
    input  logic                     D_ready,
    output logic                     D_valid,
    output logic [31:0]              D_Pc,
    output logic [31:0]              D_Instr,
    output logic                     D_Exc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic        exc_mem   [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic fetch_exc;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign D_valid = ~empty;
    assign pop     = D_valid & D_ready;
    assign push    = ~flush & (~full | pop);
    // The PC must also load on flush so the redirect target gets fetched.
    assign EN_Pc   = flush | ~full | pop;
    assign count   = count_q;

    assign fetch_exc = (F_Pc[1:0] != 2'b00) | (F_Pc < PC_BASE) | (F_Pc > PC_LIMIT);

    // Masked when empty so decode never sees a stale entry.
    assign D_Pc    = empty ? 32'h0 : pc_mem[rd_ptr_q];
    assign D_Instr = empty ? 32'h0 : instr_mem[rd_ptr_q];
    assign D_Exc   = empty ? 1'b0  : exc_mem[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            exc_mem[wr_ptr_q]   <= fetch_exc;
            pc_mem[wr_ptr_q]    <= F_Pc;
            instr_mem[wr_ptr_q] <= fetch_exc ? 32'h0 : F_Instr;
        end
    end

endmodule

// File: tb/tb_f_fetch_queue.sv
// Directed bench for f_fetch_queue: reset, fill/stall, wrap-around streaming,
// flush, fetch exceptions and asynchronous reset mid-operation.
module tb_f_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] F_Pc;
    logic [31:0] F_Instr;
    logic        flush;
    logic        EN_Pc;
    logic        D_ready;
    logic        D_valid;
    logic [31:0] D_Pc;
    logic [31:0] D_Instr;
    logic        D_Exc;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    f_fetch_queue dut (
        .clk     (clk),
        .reset   (reset),
        .F_Pc    (F_Pc),
        .F_Instr (F_Instr),
        .flush   (flush),
        .EN_Pc   (EN_Pc),
        .D_ready (D_ready),
        .D_valid (D_valid),
        .D_Pc    (D_Pc),
        .D_Instr (D_Instr),
        .D_Exc   (D_Exc),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released at posedge+1 with the queue empty.
    task automatic do_reset();
        reset   = 1'b0;
        flush   = 1'b0;
        D_ready = 1'b0;
        F_Pc    = 32'h0000_3000;
        F_Instr = word_of(32'h0000_3000);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        flush   = 1'b0;
        D_ready = 1'b1;
        F_Pc    = 32'h0000_3000;
        F_Instr = word_of(32'h0000_3000);
        tick();
        tick();
        n_cmp++; if (D_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", D_valid); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (EN_Pc !== 1'b1) begin n_err++; $display("FAIL rst_en_pc: got %b want 1", EN_Pc); end
        n_cmp++; if ({D_Pc, D_Instr, D_Exc} !== 65'h0) begin
            n_err++; $display("FAIL rst_outputs: got %h/%h/%b want 0", D_Pc, D_Instr, D_Exc);
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (D_valid !== 1'b0) begin n_err++; $display("FAIL rel_valid: got %b want 0", D_valid); end
        tick();
        n_cmp++; if (D_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", D_valid); end
        n_cmp++; if (D_Pc !== 32'h0000_3000) begin n_err++; $display("FAIL first_pc: got %h want 00003000", D_Pc); end
        n_cmp++; if (D_Instr !== 32'hC0DE_3000) begin n_err++; $display("FAIL first_instr: got %h want c0de3000", D_Instr); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL first_count: got %0d want 1", count); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            F_Pc    = 32'h0000_3000 + 32'(4 * i);
            F_Instr = word_of(F_Pc);
            tick();
            n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
        end
        n_cmp++; if (EN_Pc !== 1'b0) begin n_err++; $display("FAIL full_en_pc: got %b want 0", EN_Pc); end
        n_cmp++; if (D_Pc !== 32'h0000_3000) begin n_err++; $display("FAIL full_head: got %h want 00003000", D_Pc); end
        tick();
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_hold: got %0d want 4", count); end
        n_cmp++; if (D_Pc !== 32'h0000_3000) begin n_err++; $display("FAIL stall_head: got %h want 00003000", D_Pc); end
        D_ready = 1'b1;
        F_Pc    = 32'h0000_3010;
        F_Instr = word_of(F_Pc);
        #1;
        n_cmp++; if (EN_Pc !== 1'b1) begin n_err++; $display("FAIL full_pop_en_pc: got %b want 1", EN_Pc); end
        tick();
        D_ready = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_pop_count: got %0d want 4", count); end
        n_cmp++; if (D_Pc !== 32'h0000_3004) begin n_err++; $display("FAIL full_pop_head: got %h want 00003004", D_Pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] pc_next;
        logic [31:0] exp_pc;
        logic        en;
        int          pops;
        int          cyc;
        do_reset();
        pc_next = 32'h0000_3000;
        exp_pc  = 32'h0000_3000;
        pops    = 0;
        cyc     = 0;
        while (pops < 10 && cyc < 80) begin
            D_ready = (cyc % 2 == 0);
            F_Pc    = pc_next;
            F_Instr = word_of(pc_next);
            #1;
            if (D_valid && D_ready) begin
                n_cmp++; if (D_Pc !== exp_pc) begin n_err++; $display("FAIL wrap_pc: got %h want %h", D_Pc, exp_pc); end
                n_cmp++; if (D_Instr !== word_of(exp_pc)) begin
                    n_err++; $display("FAIL wrap_instr: got %h want %h", D_Instr, word_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            en = EN_Pc;
            tick();
            if (en) pc_next = pc_next + 32'd4;
            cyc++;
        end
        D_ready = 1'b0;
        n_cmp++; if (pops != 10) begin n_err++; $display("FAIL wrap_timeout: got %0d pops want 10", pops); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            F_Pc    = 32'h0000_3000 + 32'(4 * i);
            F_Instr = word_of(F_Pc);
            tick();
        end
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush   = 1'b1;
        F_Pc    = 32'h0000_300C;
        F_Instr = word_of(F_Pc);
        #1;
        n_cmp++; if (EN_Pc !== 1'b1) begin n_err++; $display("FAIL flush_en_pc: got %b want 1", EN_Pc); end
        tick();
        flush   = 1'b0;
        F_Pc    = 32'h0000_3100;
        F_Instr = word_of(F_Pc);
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (D_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", D_valid); end
        n_cmp++; if (D_Pc !== 32'h0) begin n_err++; $display("FAIL flush_mask: got %h want 0", D_Pc); end
        tick();
        n_cmp++; if (D_Pc !== 32'h0000_3100) begin n_err++; $display("FAIL redirect_pc: got %h want 00003100", D_Pc); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL redirect_count: got %0d want 1", count); end
        // Flush while full must still enable the PC.
        for (int i = 0; i < 3; i++) begin
            F_Pc = 32'h0000_3104 + 32'(4 * i);
            tick();
        end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL refill_count: got %0d want 4", count); end
        flush = 1'b1;
        #1;
        n_cmp++; if (EN_Pc !== 1'b1) begin n_err++; $display("FAIL flush_full_en_pc: got %b want 1", EN_Pc); end
        tick();
        flush = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_full_count: got %0d want 0", count); end
    endtask

    task automatic test_exc();
        logic [31:0] pcs   [5];
        logic        excs  [5];
        logic [31:0] instr [5];
        pcs[0] = 32'h0000_3002; excs[0] = 1'b1; instr[0] = 32'h0;
        pcs[1] = 32'h0000_7000; excs[1] = 1'b1; instr[1] = 32'h0;
        pcs[2] = 32'h0000_2FFC; excs[2] = 1'b1; instr[2] = 32'h0;
        pcs[3] = 32'h0000_6FFC; excs[3] = 1'b0; instr[3] = 32'hDEAD_BEEF;
        pcs[4] = 32'h0000_3000; excs[4] = 1'b0; instr[4] = 32'hDEAD_BEEF;
        do_reset();
        D_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            F_Pc    = pcs[i];
            F_Instr = 32'hDEAD_BEEF;
            tick();
            n_cmp++; if (D_Pc !== pcs[i]) begin n_err++; $display("FAIL exc_pc: got %h want %h", D_Pc, pcs[i]); end
            n_cmp++; if (D_Exc !== excs[i]) begin
                n_err++; $display("FAIL exc_flag @%h: got %b want %b", pcs[i], D_Exc, excs[i]);
            end
            n_cmp++; if (D_Instr !== instr[i]) begin
                n_err++; $display("FAIL exc_instr @%h: got %h want %h", pcs[i], D_Instr, instr[i]);
            end
        end
        D_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            F_Pc    = 32'h0000_3000 + 32'(4 * i);
            F_Instr = word_of(F_Pc);
            tick();
        end
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL async_pre_count: got %0d want 2", count); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (D_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", D_valid); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", count); end
        n_cmp++; if (D_Pc !== 32'h0) begin n_err++; $display("FAIL async_pc: got %h want 0", D_Pc); end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        D_ready = 1'b0;
        F_Pc    = 32'h0;
        F_Instr = 32'h0;
        test_reset();
        test_fill();
        test_wrap();
        test_flush();
        test_exc();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
